// File: rtl/tube_scan_if.sv
// Requester-side bundle of the shared seven-segment tube: per-requester
// request, digit data and blanking in; owner grant and tube drive out.
interface tube_scan_if #(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ*32-1:0] digits_flat;
    logic [N_REQ*8-1:0]  blank_flat;
    logic [N_REQ-1:0]    grant;
    logic [7:0]          seg_out;
    logic [7:0]          seg_en;

    modport master (
        output req, digits_flat, blank_flat,
        input  grant, seg_out, seg_en
    );

    modport slave (
        input  req, digits_flat, blank_flat,
        output grant, seg_out, seg_en
    );
endinterface

// File: rtl/tube_scan_arbiter.sv
// Fixed-priority owner of the 8-digit active-low tube with a frame-counted
// minimum hold, per-frame snapshot of the owner's data and hex decode.
module tube_scan_arbiter #(
    parameter int N_REQ    = 3,
    parameter int SCAN_DIV = 50000,
    parameter int MIN_HOLD = 4
) (
    input  logic      clk,
    input  logic      rst,
    tube_scan_if.slave bus
);

    localparam int OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int FC_W  = $clog2(MIN_HOLD + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MIN_HOLD);

    typedef enum logic {
        IDLE,
        SCAN
    } state_e;

    state_e             state_q,       state_d;
    logic [OWN_W-1:0]   owner_q,       owner_d;
    logic [N_REQ-1:0]   grant_q,       grant_d;
    logic [7:0]         seg_out_q,     seg_out_d;
    logic [7:0]         seg_en_q,      seg_en_d;
    logic [2:0]         idx_q,         idx_d;
    logic [DIV_W-1:0]   div_q,         div_d;
    logic [FC_W-1:0]    frame_cnt_q,   frame_cnt_d;
    logic [31:0]        snap_digits_q, snap_digits_d;
    logic [7:0]         snap_blank_q,  snap_blank_d;

    logic               any_req;
    logic               do_load;
    logic [OWN_W-1:0]   new_owner;
    logic [FC_W-1:0]    fc_inc;
    logic [31:0]        ld_digits;
    logic [7:0]         ld_blank;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] digit_seg(input logic [31:0] d,
                                             input logic [7:0]  b,
                                             input logic [2:0]  i);
        return b[i] ? 8'hFF : hex_to_seg(d[{i, 2'b00} +: 4]);
    endfunction

    // Scanning from the top down leaves the lowest set index as the winner.
    function automatic logic [OWN_W-1:0] lowest_req(input logic [N_REQ-1:0] r);
        logic [OWN_W-1:0] w;
        w = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (r[i]) w = OWN_W'(i);
        end
        return w;
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block leaves one unassigned and a latch is never inferred.
        state_d       = state_q;
        owner_d       = owner_q;
        grant_d       = grant_q;
        seg_out_d     = seg_out_q;
        seg_en_d      = seg_en_q;
        idx_d         = idx_q;
        div_d         = div_q;
        frame_cnt_d   = frame_cnt_q;
        snap_digits_d = snap_digits_q;
        snap_blank_d  = snap_blank_q;
        any_req       = |bus.req;
        do_load       = 1'b0;
        new_owner     = owner_q;
        fc_inc        = (frame_cnt_q == FC_MAX) ? frame_cnt_q : frame_cnt_q + 1'b1;
        ld_digits     = '0;
        ld_blank      = '0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    do_load     = 1'b1;
                    new_owner   = lowest_req(bus.req);
                    frame_cnt_d = '0;
                end
            end

            SCAN: begin
                div_d = div_q + 1'b1;
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (idx_q != 3'd7) begin
                        idx_d     = idx_q + 3'd1;
                        seg_en_d  = ~(8'b1 << idx_d);
                        seg_out_d = digit_seg(snap_digits_q, snap_blank_q, idx_d);
                    end else if (!any_req) begin
                        state_d     = IDLE;
                        grant_d     = '0;
                        seg_en_d    = 8'hFF;
                        seg_out_d   = 8'hFF;
                        idx_d       = '0;
                        frame_cnt_d = '0;
                    end else begin
                        do_load = 1'b1;
                        // grant_q is one-hot of the owner, so this is req[owner].
                        if (|(bus.req & grant_q) &&
                            (int'(frame_cnt_q) + 1 < MIN_HOLD)) begin
                            new_owner   = owner_q;
                            frame_cnt_d = fc_inc;
                        end else begin
                            new_owner   = lowest_req(bus.req);
                            frame_cnt_d = (new_owner == owner_q) ? fc_inc : '0;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // Frame start: take a fresh snapshot and show its digit 0 on this edge.
        if (do_load) begin
            for (int r = 0; r < N_REQ; r++) begin
                if (new_owner == OWN_W'(r)) begin
                    ld_digits = bus.digits_flat[32*r +: 32];
                    ld_blank  = bus.blank_flat[8*r +: 8];
                end
                grant_d[r] = (new_owner == OWN_W'(r));
            end
            state_d       = SCAN;
            owner_d       = new_owner;
            snap_digits_d = ld_digits;
            snap_blank_d  = ld_blank;
            idx_d         = '0;
            div_d         = '0;
            seg_en_d      = 8'hFE;
            seg_out_d     = digit_seg(ld_digits, ld_blank, 3'd0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            grant_q     <= '0;
            seg_out_q   <= 8'hFF;
            seg_en_q    <= 8'hFF;
            idx_q       <= '0;
            div_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            grant_q     <= grant_d;
            seg_out_q   <= seg_out_d;
            seg_en_q    <= seg_en_d;
            idx_q       <= idx_d;
            div_q       <= div_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // NOTE: the snapshot is pure datapath, always reloaded before it is
    // displayed, so it carries no reset.
    always_ff @(posedge clk) begin
        snap_digits_q <= snap_digits_d;
        snap_blank_q  <= snap_blank_d;
    end

    assign bus.grant   = grant_q;
    assign bus.seg_out = seg_out_q;
    assign bus.seg_en  = seg_en_q;

endmodule

// File: tb/tb_tube_scan_arbiter.sv
// Directed bench for tube_scan_arbiter: idle, single owner scan, snapshot
// integrity, hold/preemption, blanking/release and reset mid-frame.
module tb_tube_scan_arbiter;

    localparam int N_REQ    = 3;
    localparam int SCAN_DIV = 4;
    localparam int MIN_HOLD = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    tube_scan_if #(.N_REQ(N_REQ)) bus ();

    tube_scan_arbiter #(
        .N_REQ    (N_REQ),
        .SCAN_DIV (SCAN_DIV),
        .MIN_HOLD (MIN_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] hex7(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
            4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
            4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
            4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
        endcase
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [2:0] g,
                             input logic [7:0] en, input logic [7:0] so);
        check({tag, "_grant"},   32'(bus.grant),   32'(g));
        check({tag, "_seg_en"},  32'(bus.seg_en),  32'(en));
        check({tag, "_seg_out"}, 32'(bus.seg_out), 32'(so));
    endtask

    // Advance slot by slot through digits first..last, checking each one.
    task automatic walk(input string tag, input logic [2:0] g, input logic [31:0] d,
                        input logic [7:0] b, input int first, input int last);
        logic [7:0] so;
        for (int i = first; i <= last; i++) begin
            step(SCAN_DIV);
            so = b[i] ? 8'hFF : hex7(d[4*i +: 4]);
            check_out($sformatf("%s_d%0d", tag, i), g, ~(8'b1 << i), so);
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.req         = '0;
        bus.digits_flat = '0;
        bus.blank_flat  = '0;

        step(3);
        check_out("reset", 3'b000, 8'hFF, 8'hFF);
        rst = 1'b0;
        step(100);
        check_out("idle_hold", 3'b000, 8'hFF, 8'hFF);

        // Single requester r1, one-cycle latency, full digit walk.
        bus.digits_flat[63:32] = 32'h7654_3210;
        bus.req                = 3'b010;
        step(1);
        check_out("r1_f1_d0", 3'b010, 8'hFE, 8'hC0);
        walk("r1_f1", 3'b010, 32'h7654_3210, 8'h00, 1, 7);
        step(SCAN_DIV);
        check_out("r1_f2_d0", 3'b010, 8'hFE, 8'hC0);

        // Live data change mid-frame is not shown until the next frame.
        walk("r1_f2", 3'b010, 32'h7654_3210, 8'h00, 1, 2);
        bus.digits_flat[63:32] = 32'hFFFF_FFFF;
        walk("r1_f2_old", 3'b010, 32'h7654_3210, 8'h00, 3, 7);
        step(SCAN_DIV);
        check_out("r1_f3_d0", 3'b010, 8'hFE, 8'h8E);
        walk("r1_f3", 3'b010, 32'hFFFF_FFFF, 8'h00, 1, 6);

        // r1 drops, r2 takes over at the boundary.
        bus.digits_flat[95:64] = 32'hFEDC_BA98;
        bus.req                = 3'b100;
        walk("r1_f3_end", 3'b010, 32'hFFFF_FFFF, 8'h00, 7, 7);
        step(SCAN_DIV);
        check_out("r2_f1_d0", 3'b100, 8'hFE, 8'h80);

        // r0 requests mid-frame 1; r2 holds through frame 2.
        walk("r2_f1", 3'b100, 32'hFEDC_BA98, 8'h00, 1, 2);
        bus.req = 3'b101;
        walk("r2_f1_pre", 3'b100, 32'hFEDC_BA98, 8'h00, 3, 7);
        step(SCAN_DIV);
        check_out("r2_f2_d0", 3'b100, 8'hFE, 8'h80);
        bus.digits_flat[31:0] = 32'h1234_5678;
        bus.blank_flat[7:0]   = 8'h0F;
        walk("r2_f2", 3'b100, 32'hFEDC_BA98, 8'h00, 1, 7);
        step(SCAN_DIV);
        check_out("r0_d0", 3'b001, 8'hFE, 8'hFF);

        // Blanked low digits; dropping all requests lets the frame finish.
        walk("r0_blank", 3'b001, 32'h1234_5678, 8'h0F, 1, 3);
        bus.req = 3'b000;
        walk("r0_tail", 3'b001, 32'h1234_5678, 8'h0F, 4, 7);
        step(SCAN_DIV);
        check_out("release", 3'b000, 8'hFF, 8'hFF);
        step(20);
        check_out("release_idle", 3'b000, 8'hFF, 8'hFF);

        // Reset while digit 5 is showing, then restart.
        bus.blank_flat = '0;
        bus.req        = 3'b001;
        step(1);
        check_out("r0b_d0", 3'b001, 8'hFE, 8'h80);
        walk("r0b", 3'b001, 32'h1234_5678, 8'h00, 1, 5);
        rst = 1'b1;
        step(1);
        check_out("rst_mid", 3'b000, 8'hFF, 8'hFF);
        rst = 1'b0;
        step(1);
        check_out("rst_restart_d0", 3'b001, 8'hFE, 8'h80);
        walk("rst_restart", 3'b001, 32'h1234_5678, 8'h00, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
